branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 117 +++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Purpose  : 16-entry table of 2-bit saturating counters indexed by pc[4:1].
//            Gives a combinational taken/not-taken prediction for the fetch PC,
//            trains on branches resolving in execute, and raises a registered
//            one-cycle mispredict pulse with the corrected next PC.
// Ports    : clk, rst (async, active-high)
//            fetch_pc[15:0]  -> pred_taken
//            ex_brch_valid, ex_pc[15:0], ex_target[15:0], ex_brch_taken,
//            ex_pred_taken   -> mispredict, redirect_pc[15:0]
//            stat_brch[15:0], stat_mispred[15:0] (only with the macro below)
// Config   : BRANCH_PREDICTOR_STATS_EN adds branch / mispredict counters.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] fetch_pc,
  output logic        pred_taken,
  input  logic        ex_brch_valid,
  input  logic [15:0] ex_pc,
  input  logic [15:0] ex_target,
  input  logic        ex_brch_taken,
  input  logic        ex_pred_taken,
  output logic        mispredict,
  output logic [15:0] redirect_pc
`ifdef BRANCH_PREDICTOR_STATS_EN
  ,
  output logic [15:0] stat_brch,
  output logic [15:0] stat_mispred
`endif
);

  localparam logic [1:0] c_CNT_WNT = 2'b01;  // weakly not-taken
  localparam logic [1:0] c_CNT_MAX = 2'b11;
  localparam logic [1:0] c_CNT_MIN = 2'b00;

  logic [1:0]  cnt_q [16];
  logic [1:0]  cnt_d;
  logic [1:0]  w_cnt_cur;
  logic [3:0]  w_fetch_idx;
  logic [3:0]  w_ex_idx;
  logic        mispredict_q;
  logic        mispredict_d;
  logic [15:0] redirect_q;
  logic [15:0] redirect_d;

  // Bits of the fetch PC that do not participate in indexing.
  logic w_unused_bits;
  assign w_unused_bits = ^{fetch_pc[15:5], fetch_pc[0]};

  assign w_fetch_idx = fetch_pc[4:1];
  assign w_ex_idx    = ex_pc[4:1];
  assign w_cnt_cur   = cnt_q[w_ex_idx];

  // Read straight from the stored table: a same-cycle update is not bypassed.
  assign pred_taken  = cnt_q[w_fetch_idx][1];

  always_comb begin
    cnt_d = w_cnt_cur;
    if (ex_brch_taken) begin
      if (w_cnt_cur != c_CNT_MAX) cnt_d = w_cnt_cur + 2'd1;
    end else begin
      if (w_cnt_cur != c_CNT_MIN) cnt_d = w_cnt_cur - 2'd1;
    end
  end

  always_comb begin
    mispredict_d = ex_brch_valid && (ex_brch_taken != ex_pred_taken);
    redirect_d   = redirect_q;
    if (mispredict_d) begin
      redirect_d = ex_brch_taken ? ex_target : (ex_pc + 16'd2);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) cnt_q[i] <= c_CNT_WNT;
    end else if (ex_brch_valid) begin
      cnt_q[w_ex_idx] <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict_q <= 1'b0;
      redirect_q   <= 16'h0000;
    end else begin
      mispredict_q <= mispredict_d;
      redirect_q   <= redirect_d;
    end
  end

  assign mispredict  = mispredict_q;
  assign redirect_pc = redirect_q;

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [15:0] stat_brch_q;
  logic [15:0] stat_mispred_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_brch_q    <= 16'h0000;
      stat_mispred_q <= 16'h0000;
    end else begin
      if (ex_brch_valid) stat_brch_q    <= stat_brch_q + 16'd1;
      if (mispredict_d)  stat_mispred_q <= stat_mispred_q + 16'd1;
    end
  end

  assign stat_brch    = stat_brch_q;
  assign stat_mispred = stat_mispred_q;
`endif

endmodule
`default_nettype wire
